// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: ALU opcodes, arbiter FSM states,
// the maximum requester count and a small wrap-around increment helper.
package alu_arbiter_pkg;

  localparam int ALU_ARB_MAX_NREQ = 8;
  localparam int ALU_ARB_IDX_W    = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic {
    ARB_IDLE_RR = 1'b0,
    ARB_LOCK    = 1'b1
  } arb_state_e;

  // Next requester index after idx, wrapping back to 0 at n.
  function automatic logic [ALU_ARB_IDX_W-1:0] wrapInc(input logic [ALU_ARB_IDX_W-1:0] idx,
                                                       input int unsigned n);
    logic [31:0] nxt;
    nxt = {29'b0, idx} + 32'd1;
    if (nxt >= n) return '0;
    return ALU_ARB_IDX_W'(nxt);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Plain 32-bit combinational ALU shared by all requesters of the arbiter.
// Arithmetic wraps modulo 2^32; shift amounts use src_b[4:0].
import alu_arbiter_pkg::*;

module alu_arbiter_alu (
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = src_b_i[4:0];

  // Select the operation result; unknown encodings yield zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = src_a_i + src_b_i;
      ALU_SUB:  result_o = src_a_i - src_b_i;
      ALU_AND:  result_o = src_a_i & src_b_i;
      ALU_OR:   result_o = src_a_i | src_b_i;
      ALU_XOR:  result_o = src_a_i ^ src_b_i;
      ALU_SLL:  result_o = src_a_i << shamt;
      ALU_SRL:  result_o = src_a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(src_a_i) >>> shamt);
      ALU_SLT:  result_o = {31'b0, $signed(src_a_i) < $signed(src_b_i)};
      ALU_SLTU: result_o = {31'b0, src_a_i < src_b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Turns a request vector plus a starting pointer into a one-hot grant.
// Default: first set request searching upward from ptr_i, wrapping.
// With ALU_ARB_FIXED_PRIO_EN defined: lowest-index request wins, ptr_i ignored.
import alu_arbiter_pkg::*;

module alu_arbiter_rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]          req_i,
  input  logic [ALU_ARB_IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]          grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unusedPtr;
  assign unusedPtr = ^ptr_i;

  // Fixed priority: the lowest-index request takes the grant.
  always_comb begin
    logic found;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  // Round robin: walk NREQ positions starting at the pointer, first hit wins.
  always_comb begin
    logic        found;
    logic [31:0] idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ({29'b0, ptr_i} + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (32'(i) == idx) && req_i[i]) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters with round-robin grant, an optional
// per-requester lock for back-to-back ops, and registered result buffers.
// Build option: ALU_ARB_FIXED_PRIO_EN selects lowest-index-first arbitration
// (round-robin pointer held at 0); lock behaviour is unchanged.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_src_a,
  input  logic [NREQ-1:0][31:0] req_src_b,
  input  alu_op_e [NREQ-1:0]    req_op,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ-1:0][31:0] resp_result
);

  arb_state_e                 state_q, state_d;
  logic [ALU_ARB_IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [ALU_ARB_IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]            respValid_q;
  logic [NREQ-1:0][31:0]      respResult_q;

  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            pickGrant;
  logic [NREQ-1:0]            grant;
  logic [ALU_ARB_IDX_W-1:0]   grantIdx;
  logic                       grantLock;
  logic [31:0]                aluA, aluB, aluResult;
  alu_op_e                    aluOp;

  // A requester may issue when its buffer is empty or is being drained now.
  assign eligible = req_valid & (~respValid_q | resp_ready);

  alu_arbiter_rr_picker #(.NREQ(NREQ)) uPicker (
    .req_i   (eligible),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant)
  );

  // Grant selection: the lock owner alone while locked, the picker otherwise, none in reset.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (state_q == ARB_LOCK) begin
        for (int i = 0; i < NREQ; i++) begin
          if (ALU_ARB_IDX_W'(i) == owner_q) grant[i] = eligible[i];
        end
      end else begin
        grant = pickGrant;
      end
    end
  end

  assign req_ready = grant;

  // Route the granted requester to the ALU; requester 0 drives it when idle.
  always_comb begin
    grantIdx  = '0;
    grantLock = 1'b0;
    aluA      = req_src_a[0];
    aluB      = req_src_b[0];
    aluOp     = req_op[0];
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grantIdx  = ALU_ARB_IDX_W'(i);
        grantLock = req_lock[i];
        aluA      = req_src_a[i];
        aluB      = req_src_b[i];
        aluOp     = req_op[i];
      end
    end
  end

  alu_arbiter_alu uAlu (
    .src_a_i  (aluA),
    .src_b_i  (aluB),
    .op_i     (aluOp),
    .result_o (aluResult)
  );

  // Arbiter next state: only a grant moves the pointer, enters or leaves the lock.
  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    owner_d = owner_q;
    if (|grant) begin
      if (state_q == ARB_IDLE_RR) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        rrPtr_d = '0;
`else
        rrPtr_d = wrapInc(grantIdx, NREQ);
`endif
        if (grantLock) begin
          state_d = ARB_LOCK;
          owner_d = grantIdx;
        end
      end else if (!grantLock) begin
        state_d = ARB_IDLE_RR;
`ifdef ALU_ARB_FIXED_PRIO_EN
        rrPtr_d = '0;
`else
        rrPtr_d = wrapInc(owner_q, NREQ);
`endif
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE_RR;
      rrPtr_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      owner_q <= owner_d;
    end
  end

  // Result buffers: fill on grant, empty when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      respValid_q  <= '0;
      respResult_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          respValid_q[i]  <= 1'b1;
          respResult_q[i] <= aluResult;
        end else if (resp_ready[i]) begin
          respValid_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign resp_valid  = respValid_q;
  assign resp_result = respResult_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of grants, lock ownership and result buffers.
import alu_arbiter_pkg::*;

module tb_alu_arbiter;

  localparam int NREQ = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_src_a;
  logic [NREQ-1:0][31:0] req_src_b;
  alu_op_e [NREQ-1:0]    req_op;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [NREQ-1:0][31:0] resp_result;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit        lockedM = 1'b0;
  int        ownerM  = 0;
  int        rrM     = 0;
  bit        expValid [NREQ];
  bit [31:0] expResult[NREQ];

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src_a   (req_src_a),
    .req_src_b   (req_src_b),
    .req_op      (req_op),
    .req_lock    (req_lock),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
  );

  function automatic bit [31:0] aluModel(input alu_op_e op, input bit [31:0] a, input bit [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic bit elig(input int i);
    return req_valid[i] && (!expValid[i] || resp_ready[i]);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model.
  task automatic checkOutput();
    int g;
    logic [NREQ-1:0] expReady;
    int idx;
    g = -1;
    if (!reset) begin
      if (lockedM) begin
        if (elig(ownerM)) g = ownerM;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (rrM + k) % NREQ;
`endif
          if (g < 0 && elig(idx)) g = idx;
        end
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;

    checkVal("req_ready", 32'(req_ready), 32'(expReady));
    for (int i = 0; i < NREQ; i++) begin
      checkVal($sformatf("resp_valid[%0d]", i), 32'(resp_valid[i]), 32'(expValid[i]));
      checkVal($sformatf("resp_result[%0d]", i), resp_result[i], expResult[i]);
    end

    if (reset) begin
      lockedM = 1'b0;
      ownerM  = 0;
      rrM     = 0;
      for (int i = 0; i < NREQ; i++) begin
        expValid[i]  = 1'b0;
        expResult[i] = 32'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == g) begin
          expValid[i]  = 1'b1;
          expResult[i] = aluModel(req_op[i], req_src_a[i], req_src_b[i]);
        end else if (resp_ready[i]) begin
          expValid[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        if (lockedM) begin
          if (!req_lock[g]) begin
            lockedM = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
            rrM = 0;
`else
            rrM = (g + 1) % NREQ;
`endif
          end
        end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          rrM = 0;
`else
          rrM = (g + 1) % NREQ;
`endif
          if (req_lock[g]) begin
            lockedM = 1'b1;
            ownerM  = g;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs away from the rising edge, then check it.
  task automatic applyStimulus(input bit rst, input bit [1:0] v, input bit [1:0] rr,
                               input bit [1:0] lk,
                               input alu_op_e o0, input bit [31:0] a0, input bit [31:0] b0,
                               input alu_op_e o1, input bit [31:0] a1, input bit [31:0] b1);
    @(negedge clk);
    reset        = rst;
    req_valid    = v;
    resp_ready   = rr;
    req_lock     = lk;
    req_op[0]    = o0;
    req_src_a[0] = a0;
    req_src_b[0] = b0;
    req_op[1]    = o1;
    req_src_a[1] = a1;
    req_src_b[1] = b1;
    #1;
    checkOutput();
  endtask

  task automatic idle(input bit rst);
    applyStimulus(rst, 2'b00, 2'b11, 2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_lock   = '0;
    req_src_a  = '0;
    req_src_b  = '0;
    req_op     = {ALU_ADD, ALU_ADD};
    for (int i = 0; i < NREQ; i++) begin
      expValid[i]  = 1'b0;
      expResult[i] = 32'd0;
    end

    $display("[TB] reset state");
    idle(1'b1);
    checkVal("reset resp_valid", 32'(resp_valid), 32'd0);
    checkVal("reset req_ready", 32'(req_ready), 32'd0);

    $display("[TB] single op");
    applyStimulus(0, 2'b01, 2'b11, 2'b00, ALU_ADD, 5, 7, ALU_ADD, 0, 0);
    checkVal("t1 grant", 32'(req_ready), 32'b01);
    idle(1'b0);
    checkVal("t1 valid", 32'(resp_valid), 32'b01);
    checkVal("t1 result", resp_result[0], 32'd12);

    $display("[TB] contention");
    idle(1'b1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 2'b11, 2'b11, 2'b00, ALU_ADD, 1, 2, ALU_SUB, 3, 5);
`ifndef ALU_ARB_FIXED_PRIO_EN
      checkVal($sformatf("t2 grant c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'b01 : 32'b10);
      if (c == 2) checkVal("t2 sub result", resp_result[1], 32'hFFFF_FFFE);
`endif
    end

    $display("[TB] back-pressure");
    idle(1'b1);
    applyStimulus(0, 2'b01, 2'b10, 2'b00, ALU_SLL, 1, 4, ALU_ADD, 0, 0);
    checkVal("t3 first grant", 32'(req_ready), 32'b01);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 2'b01, 2'b10, 2'b00, ALU_ADD, 1, 1, ALU_ADD, 0, 0);
      checkVal("t3 stalled", 32'(req_ready), 32'b00);
      checkVal("t3 held", resp_result[0], 32'd16);
    end
    applyStimulus(0, 2'b01, 2'b11, 2'b00, ALU_ADD, 1, 1, ALU_ADD, 0, 0);
    checkVal("t3 drain grant", 32'(req_ready), 32'b01);
    idle(1'b0);
    checkVal("t3 second result", resp_result[0], 32'd2);

    $display("[TB] lock");
    idle(1'b1);
    applyStimulus(0, 2'b01, 2'b11, 2'b00, ALU_OR, 8, 1, ALU_ADD, 0, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 2'b11, 2'b11, (c < 2) ? 2'b10 : 2'b00,
                    ALU_ADD, 9, 9, ALU_XOR, 32'(c), 32'hF0);
`ifndef ALU_ARB_FIXED_PRIO_EN
      checkVal($sformatf("t4 locked c%0d", c), 32'(req_ready), 32'b10);
`endif
    end
    applyStimulus(0, 2'b11, 2'b11, 2'b00, ALU_ADD, 9, 9, ALU_ADD, 1, 1);
`ifndef ALU_ARB_FIXED_PRIO_EN
    checkVal("t4 req0 fourth", 32'(req_ready), 32'b01);
`endif

    $display("[TB] reset mid-lock");
    idle(1'b1);
    applyStimulus(0, 2'b01, 2'b11, 2'b00, ALU_ADD, 1, 1, ALU_ADD, 0, 0);
    applyStimulus(0, 2'b10, 2'b11, 2'b10, ALU_ADD, 0, 0, ALU_ADD, 4, 4);
    applyStimulus(1, 2'b11, 2'b11, 2'b10, ALU_ADD, 2, 2, ALU_ADD, 4, 4);
    checkVal("t5 ready in reset", 32'(req_ready), 32'b00);
    applyStimulus(0, 2'b11, 2'b11, 2'b00, ALU_ADD, 2, 2, ALU_ADD, 4, 4);
    checkVal("t5 valid cleared", 32'(resp_valid), 32'b00);
    checkVal("t5 grant req0", 32'(req_ready), 32'b01);

`ifdef ALU_ARB_FIXED_PRIO_EN
    $display("[TB] fixed priority");
    idle(1'b1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 2'b11, 2'b11, 2'b00, ALU_ADD, 32'(c), 1, ALU_ADD, 3, 3);
      checkVal($sformatf("t6 grant c%0d", c), 32'(req_ready), 32'b01);
    end
`endif

    $display("[TB] random traffic");
    idle(1'b1);
    for (int c = 0; c < 600; c++) begin
      bit [31:0] a0, b0, a1, b1;
      a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b1 = $urandom;
      applyStimulus(($urandom_range(0, 49) == 0),
                    2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                    alu_op_e'(4'($urandom_range(0, 9))), a0, b0,
                    alu_op_e'(4'($urandom_range(0, 9))), a1, b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
